// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder cell stepped WIDTH times, LSB first.
// Result and carry-out are presented together with a one-cycle done pulse.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work_sum;
    logic [WIDTH-1:0] work_next;
    logic             carry_reg;
    logic [CW-1:0]    count;
    logic             fa_sum;
    logic             fa_c_out;

    full_adder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .c_in (carry_reg),
        .sum  (fa_sum),
        .c_out(fa_c_out)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps.
    generate
        if (WIDTH == 1) begin : g_w1
            assign work_next = fa_sum;
        end else begin : g_wn
            assign work_next = {fa_sum, work_sum[WIDTH-1:1]};
        end
    endgenerate

    assign busy = (state != IDLE);

    // Sequencer: latch operands, step the cell, publish the result once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            work_sum  <= '0;
            carry_reg <= 1'b0;
            count     <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a      <= in1;
                        op_b      <= in2;
                        carry_reg <= c_in;
                        count     <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    work_sum  <= work_next;
                    carry_reg <= fa_c_out;
                    op_a      <= op_a >> 1;
                    op_b      <= op_b >> 1;
                    count     <= count + CW'(1);
                    if (count == LAST) begin
                        sum   <= work_next;
                        c_out <= fa_c_out;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
